fetch_decode_buffer: RTL and testbench
======================================

// Module: fetch_decode_buffer
//
// PURPOSE
//  Decoupling queue between the instruction fetch unit and the decode stage.
//  Captures {instr, curr_pc, inc_pc} from the IFU and presents entries to
//  decode under a valid/ready handshake.
//  Back-pressures the IFU through its stall input and discards all queued
//  entries on a taken jump/flush.
//
// PARAMETERS
//  XLEN   32  data/address width of PC fields
//  DEPTH  2   queue entries; power of two, >= 2
//
// PORTS
//  clk          in   1        single clock, all state on posedge
//  reset        in   1        synchronous, active-high
//  in_valid     in   1        IFU presents a fetched instruction this cycle
//  instr_in     in   30       instr[31:2] from IFU (low bits implied 2'b11)
//  curr_pc_in   in   XLEN     PC of instr_in
//  inc_pc_in    in   XLEN     PC+4 of instr_in
//  stall_out    out  1        to IFU stall: hold current instruction
//  flush        in   1        taken jump/redirect: drop all entries
//  out_valid    out  1        head entry valid toward decode
//  out_ready    in   1        decode accepts head this cycle
//  instr_out    out  30       head instr[31:2]
//  curr_pc_out  out  XLEN     head PC
//  inc_pc_out   out  XLEN     head PC+4
//  count        out  $clog2(DEPTH+1)  occupancy, for perf/debug
//
// BEHAVIOUR
//  - Reset: rd/wr pointers=0, count=0; out_valid=0, stall_out=0, data outs=0.
//  - push = in_valid & ~full & ~flush; pop = out_valid & out_ready & ~flush.
//  - full = (count==DEPTH); stall_out = full. Registered state only; no comb
//    path from out_ready or in_valid to stall_out.
//  - out_valid = (count!=0). Data outs = head entry when out_valid, else 0.
//  - Latency: entry pushed at edge N is visible on outputs after edge N;
//    no same-cycle bypass from in to out.
//  - push & pop together: count unchanged; both pointers advance.
//  - Pointers: log2(DEPTH) bits, wrap naturally modulo DEPTH.
//  - Full & pop: pop completes, no push that cycle (stall_out was high);
//    stall_out deasserts next cycle.
//  - Empty & out_ready: no effect.
//  - in_valid while full: ignored. IFU holds its outputs under stall; the
//    same instruction is pushed once space exists.
//  - flush: highest priority over push/pop. Next cycle count=0, pointers=0,
//    out_valid=0, stall_out=0. Any in_valid in the flush cycle is dropped.
//  - reset mid-operation: identical to flush plus state clear; reset beats
//    flush.
//  - Storage array is not reset; visibility is gated by count.
//
// STRUCTURE
//  - Shared package fetch_pkg:
//      typedef struct packed {logic [31:2] instr; logic [XLEN-1:0] curr_pc;
//        logic [XLEN-1:0] inc_pc;} fetch_entry_t
//      localparam RV_OPC_LOW = 2'b11
//  - No sub-module. Storage array, pointers and count are inline.
//  - Top level only instantiates alongside ifu; stall_out drives ifu.stall.
//
// TESTING
//  1 reset=1 two cycles -> out_valid=0, stall_out=0, count=0, instr_out=0.
//  2 push instr 0x0000_0013>>2 @pc 0x100, out_ready=0 -> next cycle
//    out_valid=1, curr_pc_out=0x100, inc_pc_out=0x104, count=1.
//  3 fill with pc 0x100, 0x104, out_ready=0 -> stall_out=1, count=2. A third
//    in_valid @0x108 is held. Then out_ready=1 one cycle -> 0x100 popped,
//    0x108 pushed next cycle, order 0x104, 0x108.
//  4 count=1, in_valid & out_ready same cycle over 8 cycles -> count stays 1,
//    outputs stream pc 0x100..0x11C in order across pointer wrap.
//  5 count=2, flush=1 together with in_valid/out_ready -> next cycle
//    out_valid=0, count=0, stall_out=0; dropped entry never appears.
//  6 random in_valid/out_ready/flush for 10k cycles vs scoreboard model ->
//    in-order delivery; no loss except by flush; stall_out==(count==DEPTH).

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-path types: the queued IFU entry and RISC-V opcode low bits.
package fetch_pkg;

  localparam int FETCH_XLEN = 32;
  localparam logic [1:0] RV_OPC_LOW = 2'b11;

  typedef struct packed {
    logic [31:2]           instr;
    logic [FETCH_XLEN-1:0] curr_pc;
    logic [FETCH_XLEN-1:0] inc_pc;
  } fetch_entry_t;

  // Rebuilds the full 32-bit encoding from the stored upper bits.
  function automatic logic [31:0] full_instr(input logic [31:2] instr);
    return {instr, RV_OPC_LOW};
  endfunction

endpackage

// File: rtl/fetch_decode_buffer.sv
// Fetch-to-decode decoupling queue with registered back-pressure and flush.
// XLEN must match fetch_pkg::FETCH_XLEN because entries use fetch_entry_t.
module fetch_decode_buffer
  import fetch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [29:0]                instr_in,
  input  logic [XLEN-1:0]            curr_pc_in,
  input  logic [XLEN-1:0]            inc_pc_in,
  output logic                       stall_out,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [29:0]                instr_out,
  output logic [XLEN-1:0]            curr_pc_out,
  output logic [XLEN-1:0]            inc_pc_out,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t   mem_q [DEPTH];
  fetch_entry_t   mem_d [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  fetch_entry_t   head;

  always_comb begin
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
    push  = in_valid & ~full & ~flush;
    pop   = ~empty & out_ready & ~flush;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      // Storage is left as-is; count=0 hides stale entries.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{instr: instr_in, curr_pc: curr_pc_in, inc_pc: inc_pc_in};
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head        = mem_q[rd_ptr_q];
    out_valid   = ~empty;
    stall_out   = full;
    count       = count_q;
    instr_out   = empty ? '0 : head.instr;
    curr_pc_out = empty ? '0 : head.curr_pc;
    inc_pc_out  = empty ? '0 : head.inc_pc;
  end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed and scoreboard-checked bench for fetch_decode_buffer.
module tb_fetch_decode_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [29:0]       instr_in;
  logic [XLEN-1:0]   curr_pc_in;
  logic [XLEN-1:0]   inc_pc_in;
  logic              stall_out;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [29:0]       instr_out;
  logic [XLEN-1:0]   curr_pc_out;
  logic [XLEN-1:0]   inc_pc_out;
  logic [1:0]        count;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [29:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inc;
  } exp_t;

  exp_t exp_q[$];

  fetch_decode_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .instr_in    (instr_in),
    .curr_pc_in  (curr_pc_in),
    .inc_pc_in   (inc_pc_in),
    .stall_out   (stall_out),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .instr_out   (instr_out),
    .curr_pc_out (curr_pc_out),
    .inc_pc_out  (inc_pc_out),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    flush      = 1'b0;
    instr_in   = '0;
    curr_pc_in = '0;
    inc_pc_in  = '0;
  endtask

  task automatic drive_pc(input logic [XLEN-1:0] pc);
    in_valid   = 1'b1;
    instr_in   = 30'(pc >> 2) ^ 30'h0000_0004;
    curr_pc_in = pc;
    inc_pc_in  = pc + 32'd4;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", stall_out); end
    total++; if (count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (instr_out !== 30'd0) begin bad++; $display("FAIL reset_instr got=%h want=0", instr_out); end
    total++; if (curr_pc_out !== 32'd0) begin bad++; $display("FAIL reset_pc got=%h want=0", curr_pc_out); end
  endtask

  task automatic test_single_push();
    do_reset();
    in_valid   = 1'b1;
    instr_in   = 30'h0000_0004;
    curr_pc_in = 32'h100;
    inc_pc_in  = 32'h104;
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL push_out_valid got=%0b want=1", out_valid); end
    total++; if (curr_pc_out !== 32'h100) begin bad++; $display("FAIL push_pc got=%h want=100", curr_pc_out); end
    total++; if (inc_pc_out !== 32'h104) begin bad++; $display("FAIL push_inc got=%h want=104", inc_pc_out); end
    total++; if (instr_out !== 30'h4) begin bad++; $display("FAIL push_instr got=%h want=4", instr_out); end
    total++; if (count !== 2'd1) begin bad++; $display("FAIL push_count got=%0d want=1", count); end
  endtask

  task automatic test_fill_stall();
    do_reset();
    drive_pc(32'h100);
    step();
    drive_pc(32'h104);
    step();
    total++; if (stall_out !== 1'b1) begin bad++; $display("FAIL fill_stall got=%0b want=1", stall_out); end
    total++; if (count !== 2'd2) begin bad++; $display("FAIL fill_count got=%0d want=2", count); end
    drive_pc(32'h108);
    step();
    total++; if (count !== 2'd2) begin bad++; $display("FAIL held_count got=%0d want=2", count); end
    total++; if (curr_pc_out !== 32'h100) begin bad++; $display("FAIL held_head got=%h want=100", curr_pc_out); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (count !== 2'd1) begin bad++; $display("FAIL popfull_count got=%0d want=1", count); end
    total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL popfull_stall got=%0b want=0", stall_out); end
    total++; if (curr_pc_out !== 32'h104) begin bad++; $display("FAIL popfull_head got=%h want=104", curr_pc_out); end
    step();
    in_valid = 1'b0;
    total++; if (count !== 2'd2) begin bad++; $display("FAIL late_push_count got=%0d want=2", count); end
    out_ready = 1'b1;
    step();
    total++; if (curr_pc_out !== 32'h108) begin bad++; $display("FAIL order_second got=%h want=108", curr_pc_out); end
    total++; if (inc_pc_out !== 32'h10C) begin bad++; $display("FAIL order_second_inc got=%h want=10c", inc_pc_out); end
    step();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drained_valid got=%0b want=0", out_valid); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (count !== 2'd0) begin bad++; $display("FAIL empty_ready_count got=%0d want=0", count); end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] want;
    do_reset();
    drive_pc(32'h100);
    step();
    for (int i = 0; i < 8; i++) begin
      want = 32'h100 + 32'(4 * i);
      total++; if (curr_pc_out !== want) begin bad++; $display("FAIL stream_head[%0d] got=%h want=%h", i, curr_pc_out, want); end
      total++; if (instr_out !== (30'(want >> 2) ^ 30'h4)) begin bad++; $display("FAIL stream_instr[%0d] got=%h", i, instr_out); end
      drive_pc(want + 32'd4);
      out_ready = 1'b1;
      step();
      total++; if (count !== 2'd1) begin bad++; $display("FAIL stream_count[%0d] got=%0d want=1", i, count); end
    end
    total++; if (curr_pc_out !== 32'h120) begin bad++; $display("FAIL stream_tail got=%h want=120", curr_pc_out); end
    idle_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    drive_pc(32'h200);
    step();
    drive_pc(32'h204);
    step();
    drive_pc(32'h208);
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    idle_inputs();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b want=0", out_valid); end
    total++; if (count !== 2'd0) begin bad++; $display("FAIL flush_count got=%0d want=0", count); end
    total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL flush_stall got=%0b want=0", stall_out); end
    total++; if (curr_pc_out !== 32'd0) begin bad++; $display("FAIL flush_pc got=%h want=0", curr_pc_out); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_after_valid got=%0b want=0", out_valid); end
    drive_pc(32'h300);
    step();
    idle_inputs();
    total++; if (curr_pc_out !== 32'h300) begin bad++; $display("FAIL flush_refill got=%h want=300", curr_pc_out); end
    total++; if (count !== 2'd1) begin bad++; $display("FAIL flush_refill_count got=%0d want=1", count); end
    // reset while occupied and with flush/in_valid asserted clears everything
    drive_pc(32'h304);
    flush = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle_inputs();
    total++; if (count !== 2'd0) begin bad++; $display("FAIL midreset_count got=%0d want=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid got=%0b want=0", out_valid); end
  endtask

  task automatic test_random();
    bit   hold;
    bit   m_push, m_pop;
    exp_t e;
    do_reset();
    exp_q.delete();
    hold = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      flush     = ($urandom_range(0, 99) < 3);
      out_ready = ($urandom_range(0, 99) < 60);
      if (!hold) begin
        in_valid   = ($urandom_range(0, 99) < 60);
        instr_in   = 30'($urandom);
        curr_pc_in = $urandom & 32'hFFFF_FFFC;
        inc_pc_in  = curr_pc_in + 32'd4;
      end
      m_push = in_valid && (exp_q.size() < DEPTH) && !flush;
      m_pop  = (exp_q.size() != 0) && out_ready && !flush;
      e = '{instr: instr_in, pc: curr_pc_in, inc: inc_pc_in};
      hold = in_valid && !m_push && !flush;
      step();
      if (flush) exp_q.delete();
      else begin
        if (m_pop) void'(exp_q.pop_front());
        if (m_push) exp_q.push_back(e);
      end
      total++; if (count !== 2'(exp_q.size())) begin bad++; $display("FAIL rnd_count c=%0d got=%0d want=%0d", c, count, exp_q.size()); end
      total++; if (stall_out !== (exp_q.size() == DEPTH)) begin bad++; $display("FAIL rnd_stall c=%0d got=%0b", c, stall_out); end
      total++; if (out_valid !== (exp_q.size() != 0)) begin bad++; $display("FAIL rnd_valid c=%0d got=%0b", c, out_valid); end
      if (exp_q.size() != 0) begin
        total++;
        if ({instr_out, curr_pc_out, inc_pc_out} !== {exp_q[0].instr, exp_q[0].pc, exp_q[0].inc}) begin
          bad++;
          $display("FAIL rnd_head c=%0d got pc=%h instr=%h want pc=%h instr=%h", c, curr_pc_out, instr_out, exp_q[0].pc, exp_q[0].instr);
        end
      end else begin
        total++; if (curr_pc_out !== 32'd0 || instr_out !== 30'd0) begin bad++; $display("FAIL rnd_empty_data c=%0d got pc=%h", c, curr_pc_out); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_push();
    test_fill_stall();
    test_back_to_back();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
